// File: rtl/sd_card_fsm.sv
// Card-side SD bus responder: tracks card state, answers init and block read/write
// commands, and starts the response, data transmit and data receive engines.
module sd_card_fsm #(
  parameter logic [15:0] RCA       = 16'h5A5A,
  parameter int unsigned NBLOCKS   = 1024,
  parameter int unsigned PWRUP_CNT = 2
) (
  input  logic        iclk,
  input  logic        irst_n,
  input  logic        icmd_valid,
  input  logic [5:0]  icmd_index,
  input  logic [31:0] icmd_arg,
  input  logic        iresp_done,
  input  logic        idata_done,
  output logic        ostart_resp,
  output logic [1:0]  oresp_type,
  output logic [5:0]  oresp_index,
  output logic [31:0] oresp_arg,
  output logic        ostart_dtx,
  output logic        ostart_drx,
  output logic [22:0] oaddr,
  output logic        owide,
  output logic [3:0]  ostate
);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_READY = 4'd1,
    ST_IDENT = 4'd2,
    ST_STBY  = 4'd3,
    ST_TRAN  = 4'd4,
    ST_DATA  = 4'd5,
    ST_RCV   = 4'd6,
    ST_INA   = 4'hF
  } state_t;

  localparam logic [1:0] RT_R1     = 2'd1;
  localparam logic [1:0] RT_R2     = 2'd2;
  localparam logic [1:0] RT_R3     = 2'd3;
  localparam logic [3:0] PWRUP_MAX = 4'(PWRUP_CNT);

  state_t      r_state, w_state_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_app, w_app_nxt;
  logic        r_illegal, w_ill_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_pend_rd, w_pend_rd_nxt;
  logic        r_pend_wr, w_pend_wr_nxt;
  logic        r_wide, w_wide_nxt;
  logic [22:0] r_addr, w_addr_nxt;
  logic        r_start_resp, w_start_nxt;
  logic [1:0]  r_resp_type, w_rtype_nxt;
  logic [5:0]  r_resp_index, w_rindex_nxt;
  logic [31:0] r_resp_arg, w_rarg_nxt;
  logic        r_start_dtx, w_dtx_nxt;
  logic        r_start_drx, w_drx_nxt;

  logic        w_accept, w_rca_ok, w_acmd, w_oor, w_done;
  logic [3:0]  w_cnt_inc;
  logic        w_resp, w_is_r1, w_illegal, w_oor_bit, w_app_bit;
  logic [1:0]  w_rtype;
  logic [5:0]  w_rindex;
  logic [31:0] w_rarg;
  logic [31:0] w_r1_word;
  logic        w_unused_arg;

  assign w_accept  = icmd_valid && !r_busy &&
                     (r_state != ST_DATA) && (r_state != ST_RCV) && (r_state != ST_INA);
  assign w_rca_ok  = (icmd_arg[31:16] == RCA);
  assign w_acmd    = r_app && ((icmd_index == 6'd41) || (icmd_index == 6'd6));
  assign w_oor     = ({9'b0, icmd_arg[31:9]} >= NBLOCKS);
  assign w_cnt_inc = (r_cnt == PWRUP_MAX) ? r_cnt : r_cnt + 4'd1;
  assign w_done    = (w_cnt_inc == PWRUP_MAX);
  assign w_unused_arg = ^{icmd_arg[8:2], icmd_arg[0]};

  always_comb begin
    w_state_nxt   = r_state;
    w_busy_nxt    = r_busy;
    w_app_nxt     = r_app;
    w_ill_nxt     = r_illegal;
    w_cnt_nxt     = r_cnt;
    w_pend_rd_nxt = r_pend_rd;
    w_pend_wr_nxt = r_pend_wr;
    w_wide_nxt    = r_wide;
    w_addr_nxt    = r_addr;
    w_rtype_nxt   = r_resp_type;
    w_rindex_nxt  = r_resp_index;
    w_rarg_nxt    = r_resp_arg;
    w_start_nxt   = 1'b0;
    w_dtx_nxt     = 1'b0;
    w_drx_nxt     = 1'b0;
    w_resp        = 1'b0;
    w_is_r1       = 1'b0;
    w_illegal     = 1'b0;
    w_oor_bit     = 1'b0;
    w_app_bit     = 1'b0;
    w_rtype       = RT_R1;
    w_rindex      = icmd_index;
    w_rarg        = '0;

    // A data transfer only starts once the R1 for CMD17/CMD24 has left the card
    if (iresp_done) begin
      w_busy_nxt    = 1'b0;
      w_pend_rd_nxt = 1'b0;
      w_pend_wr_nxt = 1'b0;
      if (r_pend_rd) begin
        w_state_nxt = ST_DATA;
        w_dtx_nxt   = 1'b1;
      end
      if (r_pend_wr) begin
        w_state_nxt = ST_RCV;
        w_drx_nxt   = 1'b1;
      end
    end

    if (idata_done && ((r_state == ST_DATA) || (r_state == ST_RCV)))
      w_state_nxt = ST_TRAN;

    if (w_accept) begin
      w_app_nxt = 1'b0;
      if (icmd_index == 6'd0) begin
        w_state_nxt = ST_IDLE;
        w_wide_nxt  = 1'b0;
        w_cnt_nxt   = '0;
      end else if (w_acmd) begin
        w_app_bit = 1'b1;
        if (icmd_index == 6'd41) begin
          if (r_state != ST_IDLE) begin
            w_illegal = 1'b1;
          end else begin
            w_resp   = 1'b1;
            w_rtype  = RT_R3;
            w_rindex = 6'h3F;
            if (icmd_arg[21:20] == 2'b00) begin
              w_state_nxt = ST_INA;
            end else begin
              w_cnt_nxt = w_cnt_inc;
              w_rarg    = {w_done, 9'b0, 2'b11, 20'b0};
              if (w_done) w_state_nxt = ST_READY;
            end
          end
        end else if (r_state == ST_TRAN) begin
          w_wide_nxt = icmd_arg[1];
          w_resp     = 1'b1;
          w_is_r1    = 1'b1;
        end else begin
          w_illegal = 1'b1;
        end
      end else begin
        case (icmd_index)
          6'd55: begin
            if ((r_state == ST_IDLE) || ((r_state == ST_TRAN) && w_rca_ok)) begin
              w_resp    = 1'b1;
              w_is_r1   = 1'b1;
              w_app_bit = 1'b1;
              w_app_nxt = 1'b1;
            end else begin
              w_illegal = 1'b1;
            end
          end
          6'd2: begin
            if (r_state == ST_READY) begin
              w_resp      = 1'b1;
              w_rtype     = RT_R2;
              w_rindex    = 6'h3F;
              w_rarg      = {RCA, 16'h0};
              w_state_nxt = ST_IDENT;
            end else begin
              w_illegal = 1'b1;
            end
          end
          6'd3: begin
            if (r_state == ST_IDENT) begin
              w_resp      = 1'b1;
              w_rarg      = {RCA, 3'b0, r_state, 1'b1, 8'b0};
              w_state_nxt = ST_STBY;
            end else begin
              w_illegal = 1'b1;
            end
          end
          6'd7: begin
            // CMD7 addressed to another card is silently ignored while selected/selectable
            if (((r_state == ST_STBY) || (r_state == ST_TRAN)) && !w_rca_ok) begin
              w_illegal = 1'b0;
            end else if (r_state == ST_STBY) begin
              w_resp      = 1'b1;
              w_is_r1     = 1'b1;
              w_state_nxt = ST_TRAN;
            end else begin
              w_illegal = 1'b1;
            end
          end
          6'd17, 6'd24: begin
            if (r_state == ST_TRAN) begin
              w_addr_nxt = icmd_arg[31:9];
              w_resp     = 1'b1;
              w_is_r1    = 1'b1;
              w_oor_bit  = w_oor;
              if (!w_oor) begin
                w_pend_rd_nxt = (icmd_index == 6'd17);
                w_pend_wr_nxt = (icmd_index == 6'd24);
              end
            end else begin
              w_illegal = 1'b1;
            end
          end
          6'd15: begin
            if (((r_state == ST_STBY) || (r_state == ST_TRAN)) && w_rca_ok)
              w_state_nxt = ST_INA;
            else
              w_illegal = 1'b1;
          end
          default: w_illegal = 1'b1;
        endcase
      end
      if (w_illegal) w_ill_nxt = 1'b1;
    end

    w_r1_word = {w_oor_bit, 8'b0, r_illegal, 9'b0, r_state, 1'b1, 2'b0, w_app_bit, 5'b0};
    if (w_resp) begin
      w_start_nxt  = 1'b1;
      w_busy_nxt   = 1'b1;
      w_rtype_nxt  = w_rtype;
      w_rindex_nxt = w_rindex;
      w_rarg_nxt   = w_is_r1 ? w_r1_word : w_rarg;
      if (w_is_r1) w_ill_nxt = 1'b0;
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_app        <= 1'b0;
      r_illegal    <= 1'b0;
      r_cnt        <= '0;
      r_pend_rd    <= 1'b0;
      r_pend_wr    <= 1'b0;
      r_wide       <= 1'b0;
      r_addr       <= '0;
      r_start_resp <= 1'b0;
      r_resp_type  <= '0;
      r_resp_index <= '0;
      r_resp_arg   <= '0;
      r_start_dtx  <= 1'b0;
      r_start_drx  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_busy       <= w_busy_nxt;
      r_app        <= w_app_nxt;
      r_illegal    <= w_ill_nxt;
      r_cnt        <= w_cnt_nxt;
      r_pend_rd    <= w_pend_rd_nxt;
      r_pend_wr    <= w_pend_wr_nxt;
      r_wide       <= w_wide_nxt;
      r_addr       <= w_addr_nxt;
      r_start_resp <= w_start_nxt;
      r_resp_type  <= w_rtype_nxt;
      r_resp_index <= w_rindex_nxt;
      r_resp_arg   <= w_rarg_nxt;
      r_start_dtx  <= w_dtx_nxt;
      r_start_drx  <= w_drx_nxt;
    end
  end

  assign ostart_resp = r_start_resp;
  assign oresp_type  = r_resp_type;
  assign oresp_index = r_resp_index;
  assign oresp_arg   = r_resp_arg;
  assign ostart_dtx  = r_start_dtx;
  assign ostart_drx  = r_start_drx;
  assign oaddr       = r_addr;
  assign owide       = r_wide;
  assign ostate      = r_state;

endmodule

// File: tb/tb_sd_card_fsm.sv
// Bench for sd_card_fsm: command table replayed across resets plus hand-written
// sequences for data transfer, busy dropping, shutdown and asynchronous reset.
module tb_sd_card_fsm;

  localparam logic [15:0] RCA = 16'h5A5A;

  logic        iclk = 1'b0;
  logic        irst_n = 1'b0;
  logic        icmd_valid = 1'b0;
  logic [5:0]  icmd_index = '0;
  logic [31:0] icmd_arg = '0;
  logic        iresp_done = 1'b0;
  logic        idata_done = 1'b0;
  logic        ostart_resp;
  logic [1:0]  oresp_type;
  logic [5:0]  oresp_index;
  logic [31:0] oresp_arg;
  logic        ostart_dtx;
  logic        ostart_drx;
  logic [22:0] oaddr;
  logic        owide;
  logic [3:0]  ostate;

  sd_card_fsm #(.RCA(RCA), .NBLOCKS(1024), .PWRUP_CNT(2)) dut (
    .iclk(iclk), .irst_n(irst_n), .icmd_valid(icmd_valid), .icmd_index(icmd_index),
    .icmd_arg(icmd_arg), .iresp_done(iresp_done), .idata_done(idata_done),
    .ostart_resp(ostart_resp), .oresp_type(oresp_type), .oresp_index(oresp_index),
    .oresp_arg(oresp_arg), .ostart_dtx(ostart_dtx), .ostart_drx(ostart_drx),
    .oaddr(oaddr), .owide(owide), .ostate(ostate)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    logic [1:0]  rtype;
    logic [5:0]  rindex;
    logic [31:0] rarg;
  } resp_t;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    bit          resp;
    logic [1:0]  rtype;
    logic [5:0]  rindex;
    logic [31:0] rarg;
    logic [3:0]  st;
    logic [3:0]  post;
    bit          dtx;
    bit          drx;
    bit          wide;
    bit          chk_addr;
    logic [22:0] addr;
  } vec_t;

  resp_t sb_q[$];
  vec_t  vecs[13];
  int    n_checks = 0;
  int    n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Scoreboard side: every response pulse must match the oldest queued expectation
  always @(negedge iclk) begin
    resp_t e;
    if (irst_n && ostart_resp === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got response index %0d arg %h, required none",
                 oresp_index, oresp_arg);
      end else begin
        e = sb_q.pop_front();
        check("resp_type", 32'(oresp_type), 32'(e.rtype));
        check("resp_index", 32'(oresp_index), 32'(e.rindex));
        check("resp_arg", oresp_arg, e.rarg);
      end
    end
  end

  task automatic expect_resp(input logic [1:0] t, input logic [5:0] idx, input logic [31:0] arg);
    resp_t r;
    r.rtype = t; r.rindex = idx; r.rarg = arg;
    sb_q.push_back(r);
  endtask

  task automatic send(input logic [5:0] idx, input logic [31:0] arg);
    @(negedge iclk);
    icmd_valid = 1'b1; icmd_index = idx; icmd_arg = arg;
    @(negedge iclk);
    icmd_valid = 1'b0;
  endtask

  task automatic resp_done();
    iresp_done = 1'b1;
    @(negedge iclk);
    iresp_done = 1'b0;
  endtask

  task automatic data_done();
    @(negedge iclk);
    idata_done = 1'b1;
    @(negedge iclk);
    idata_done = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_state"}, 32'(ostate), 32'd0);
    check({tag, "_start"}, 32'({ostart_resp, ostart_dtx, ostart_drx, owide}), 32'd0);
    check({tag, "_rtype_idx"}, 32'({oresp_type, oresp_index}), 32'd0);
    check({tag, "_rarg"}, oresp_arg, 32'd0);
    check({tag, "_addr"}, 32'(oaddr), 32'd0);
  endtask

  task automatic run_table(input int pass);
    for (int i = 0; i < 13; i++) begin
      vec_t v;
      v = vecs[i];
      if (v.resp) expect_resp(v.rtype, v.rindex, v.rarg);
      send(v.idx, v.arg);
      check($sformatf("p%0d_v%0d_start", pass, i), 32'(ostart_resp), 32'(v.resp));
      check($sformatf("p%0d_v%0d_state", pass, i), 32'(ostate), 32'(v.st));
      check($sformatf("p%0d_v%0d_wide", pass, i), 32'(owide), 32'(v.wide));
      if (v.chk_addr) check($sformatf("p%0d_v%0d_addr", pass, i), 32'(oaddr), 32'(v.addr));
      if (v.resp) begin
        resp_done();
        check($sformatf("p%0d_v%0d_post", pass, i), 32'(ostate), 32'(v.post));
        check($sformatf("p%0d_v%0d_dtx_drx", pass, i), 32'({ostart_dtx, ostart_drx}),
              32'({v.dtx, v.drx}));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //            idx     arg            rsp typ  rindex  rarg           st    post  dtx drx wide ca addr
    vecs[0]  = '{6'd55, 32'h0000_0000, 1, 2'd1, 6'd55, 32'h0000_0120, 4'd0, 4'd0, 0, 0, 0, 0, 23'd0};
    vecs[1]  = '{6'd41, 32'h8030_0000, 1, 2'd3, 6'h3F, 32'h0030_0000, 4'd0, 4'd0, 0, 0, 0, 0, 23'd0};
    vecs[2]  = '{6'd55, 32'h0000_0000, 1, 2'd1, 6'd55, 32'h0000_0120, 4'd0, 4'd0, 0, 0, 0, 0, 23'd0};
    vecs[3]  = '{6'd41, 32'h8030_0000, 1, 2'd3, 6'h3F, 32'h8030_0000, 4'd1, 4'd1, 0, 0, 0, 0, 23'd0};
    vecs[4]  = '{6'd2,  32'h0000_0000, 1, 2'd2, 6'h3F, 32'h5A5A_0000, 4'd2, 4'd2, 0, 0, 0, 0, 23'd0};
    vecs[5]  = '{6'd3,  32'h0000_0000, 1, 2'd1, 6'd3,  32'h5A5A_0500, 4'd3, 4'd3, 0, 0, 0, 0, 23'd0};
    vecs[6]  = '{6'd17, 32'h0000_0000, 0, 2'd0, 6'd0,  32'h0,         4'd3, 4'd3, 0, 0, 0, 0, 23'd0};
    vecs[7]  = '{6'd7,  32'h5A5A_FFFF, 1, 2'd1, 6'd7,  32'h0040_0700, 4'd4, 4'd4, 0, 0, 0, 0, 23'd0};
    vecs[8]  = '{6'd7,  32'h1234_0000, 0, 2'd0, 6'd0,  32'h0,         4'd4, 4'd4, 0, 0, 0, 0, 23'd0};
    vecs[9]  = '{6'd55, 32'h5A5A_0000, 1, 2'd1, 6'd55, 32'h0000_0920, 4'd4, 4'd4, 0, 0, 0, 0, 23'd0};
    vecs[10] = '{6'd6,  32'hFFFF_FFFE, 1, 2'd1, 6'd6,  32'h0000_0920, 4'd4, 4'd4, 0, 0, 1, 0, 23'd0};
    vecs[11] = '{6'd24, 32'h0008_0000, 1, 2'd1, 6'd24, 32'h8000_0900, 4'd4, 4'd4, 0, 0, 1, 1, 23'd1024};
    vecs[12] = '{6'd17, 32'h0000_0400, 1, 2'd1, 6'd17, 32'h0000_0900, 4'd4, 4'd5, 1, 0, 1, 1, 23'd2};

    repeat (2) @(negedge iclk);
    check_zero("reset");
    irst_n = 1'b1;

    run_table(1);
    data_done();
    check("read_done_state", 32'(ostate), 32'd4);
    check("dtx_one_cycle", 32'(ostart_dtx), 32'd0);
    data_done();
    check("stray_data_done", 32'(ostate), 32'd4);

    expect_resp(2'd1, 6'd24, 32'h0000_0900);
    send(6'd24, 32'h0000_0200);
    resp_done();
    check("write_state", 32'(ostate), 32'd6);
    check("write_dtx_drx", 32'({ostart_dtx, ostart_drx}), 32'b01);
    check("write_addr", 32'(oaddr), 32'd1);
    data_done();
    check("write_done_state", 32'(ostate), 32'd4);

    send(6'd0, 32'h0);
    check("cmd0_noresp", 32'(ostart_resp), 32'd0);
    check("cmd0_state", 32'(ostate), 32'd0);
    check("cmd0_wide", 32'(owide), 32'd0);

    run_table(2);
    data_done();
    check("p2_done_state", 32'(ostate), 32'd4);

    expect_resp(2'd1, 6'd55, 32'h0000_0920);
    send(6'd55, {RCA, 16'h0});
    send(6'd55, {RCA, 16'h0});
    check("busy_drop", 32'(ostart_resp), 32'd0);
    @(negedge iclk);
    icmd_valid = 1'b1; iresp_done = 1'b1; icmd_index = 6'd55; icmd_arg = {RCA, 16'h0};
    @(negedge iclk);
    icmd_valid = 1'b0; iresp_done = 1'b0;
    check("done_same_cycle_drop", 32'(ostart_resp), 32'd0);

    send(6'd15, {RCA, 16'h0});
    check("cmd15_noresp", 32'(ostart_resp), 32'd0);
    check("cmd15_state", 32'(ostate), 32'hF);
    send(6'd0, 32'h0);
    check("ina_cmd0", 32'(ostate), 32'hF);
    send(6'd55, 32'h0);
    check("ina_cmd55", 32'({ostart_resp, ostate}), 32'h0F);

    @(negedge iclk);
    #2 irst_n = 1'b0;
    #1 check_zero("ina_reset");
    @(negedge iclk);
    irst_n = 1'b1;

    run_table(3);
    #1 irst_n = 1'b0;
    #1 check_zero("data_reset");
    @(negedge iclk);
    irst_n = 1'b1;
    repeat (2) @(negedge iclk);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_card_fsm.md
# sd_card_fsm

Card-side SD bus state machine: the responder that answers the host controller FSM's initialisation and block read/write sequence. It takes CRC-checked commands from the card command receiver and tracks the SD card state (idle → ready → ident → stby → tran → data/rcv, plus inactive). It drives the response transmitter and starts the card data transmitter or receiver. It is used as a synthesizable card model for closed-loop host verification and as the core of an emulated card.

## Interface
- RCA, 16'h5A5A, relative card address published by CMD3
- NBLOCKS, 1024, card capacity in 512-byte blocks; block addresses ≥ NBLOCKS are out of range
- PWRUP_CNT, 2, number of ACMD41 commands answered busy before the card reports power-up done (range 1..15)
- iclk  in  1  clock
- irst_n  in  1  asynchronous, active-low reset
- icmd_valid  in  1  one-cycle pulse: a command with a good CRC has been decoded
- icmd_index  in  6  command index, valid with icmd_valid
- icmd_arg  in  32  command argument, valid with icmd_valid
- iresp_done  in  1  pulse: response transmitter finished
- idata_done  in  1  pulse: data block sent or received
- ostart_resp  out  1  one-cycle pulse to start the response
- oresp_type  out  2  response type: 1 = R1/R1b/R6 (48-bit with CRC), 2 = R2 (136-bit), 3 = R3 (no CRC)
- oresp_index  out  6  index field of the response (the command index; 6'h3F for R2/R3)
- oresp_arg  out  32  response payload
- ostart_dtx  out  1  one-cycle pulse to start sending a block
- ostart_drx  out  1  one-cycle pulse to start receiving a block
- oaddr  out  23  block address latched from arg[31:9] of CMD17/CMD24
- owide  out  1  4-bit bus selected
- ostate  out  4  current card state: IDLE 0, READY 1, IDENT 2, STBY 3, TRAN 4, DATA 5, RCV 6, INA 4'hF

## Operation
- Reset values: state IDLE and all outputs 0. Internal state also resets: app flag, illegal flag, busy flag and power-up counter are all 0.
- Busy flag: set when ostart_resp is issued, cleared by iresp_done. A command arriving while busy, or while in DATA or RCV, is dropped with no side effects.
- R1 status word:
  - bit31: OUT_OF_RANGE
  - bit22: ILLEGAL_COMMAND (sticky illegal flag, cleared once reported)
  - bits12:9: state at command reception
  - bit8: 1
  - bit5: APP_CMD
- App flag: set by an accepted CMD55, cleared by the next accepted command. The next command is decoded as an ACMD only while the flag is set. APP_CMD = 1 in responses to CMD55 and to ACMDs.
- CMD0 (any state except INA): go to IDLE; clear owide, app flag and counter; no response.
- IDLE:
  - CMD55 (any arg): R1.
  - ACMD41 with arg[21:20] = 0: R3 with OCR = 0, then go to INA.
  - ACMD41 otherwise: increment the counter. Respond R3 with OCR = {done, 9'b0, 2'b11, 20'b0}, where done = (counter reaches PWRUP_CNT). When done, go to READY.
- READY: CMD2 → R2 with arg {RCA, 16'h0}, go to IDENT.
- IDENT: CMD3 → R6 with arg {RCA, 3'b0, state[3:0], 1'b1, 8'b0} (state field = 2), go to STBY.
- STBY: CMD7 with arg[31:16] == RCA → R1, go to TRAN. CMD7 with any other RCA gets no response and is not illegal.
- TRAN:
  - CMD55 with RCA match: R1.
  - ACMD6: owide ← arg[1]; R1 reports state 4.
  - CMD17 / CMD24: oaddr ← arg[31:9].
    - If the address ≥ NBLOCKS: R1 with bit31 set, stay in TRAN.
    - Otherwise R1; on the following iresp_done go to DATA (pulse ostart_dtx) or RCV (pulse ostart_drx).
- DATA / RCV: idata_done → TRAN.
- CMD15 with RCA match in STBY or TRAN: go to INA, no response.
- Commands that are not legal in the current state (other than ignored CMD7): no response, state unchanged, set the illegal flag, clear the app flag.
- INA: ignore everything until reset.

## Timing
- Command → response: ostart_resp and the new state take effect on the edge after icmd_valid (1-cycle latency). oresp_* are registered on that same edge and held until the next accepted command.
- Data start: ostart_dtx / ostart_drx pulse on the edge after iresp_done, together with the entry into DATA / RCV.
- iresp_done and a new icmd_valid in the same cycle: the command is dropped, because busy is still set that cycle.
- idata_done outside DATA/RCV: ignored.
- Reset mid-transfer: outputs drop to 0 asynchronously and the state returns to IDLE.
- Counter arithmetic: 4-bit, saturating at PWRUP_CNT.

## Test plan
- Full init (RCA = 16'h5A5A, PWRUP_CNT = 2):
  - CMD55 → R1 with bit5 = 1.
  - First ACMD41 (arg 32'h8030_0000) → OCR 32'h0030_0000.
  - Second ACMD41 → OCR 32'h8030_0000, ostate = 1.
  - CMD2 → ostate = 2.
  - CMD3 → R6 arg 32'h5A5A_0500.
  - CMD7 (arg 32'h5A5A_FFFF) → ostate = 4.
- Bus width: CMD55 + ACMD6 with arg 32'hFFFF_FFFE in TRAN → owide = 1 and R1 bits12:9 = 4.
- Read: CMD17 with arg 32'h0000_0400 → R1, then after iresp_done: ostart_dtx pulse, oaddr = 2, ostate = 5. idata_done → ostate = 4.
- Out of range: CMD24 with arg = 1024 << 9 → R1 bit31 = 1, no ostart_drx, ostate stays 4.
- Illegal command and RCA mismatch:
  - CMD17 in STBY → no ostart_resp; the next accepted command's R1 has bit22 = 1.
  - CMD7 with a wrong RCA → no response and bit22 stays 0.
- Shutdown and reset:
  - CMD15 in TRAN → ostate = 4'hF; every later command is ignored.
  - Asserting irst_n low during DATA → ostate = 0 and all outputs 0 immediately.
